led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Upstream colour source for the 8-LED serial string driver.
- Host writes per-LED colour and mode words into shadow registers. A commit strobe makes them active atomically.
- Animates blink and pulse (triangle fade) from a ms timebase and applies a global brightness.
- Drives the eight 24-bit GRB words the serializer consumes.

Parameters:
CLK_PER_MS, 100000, clk cycles per 1 ms tick (100 MHz master clock)
BLINK_MS, 250, ms per blink half-period
FADE_STEP_MS, 4, ms per pulse level step (full fade cycle = 510 steps)

Ports:
clk  input  1  master clock
reset  input  1  asynchronous, active-low reset
cfg_we  input  1  write strobe for one shadow config word
cfg_addr  input  4  LED index; 0-7 valid, 8-15 ignored
cfg_data  input  32  [23:0] GRB colour, [25:24] mode (0 off, 1 solid, 2 blink, 3 pulse), [31:26] ignored
commit  input  1  single-cycle strobe: copy all 8 shadow words to active
brightness  input  8  global gain, 0 = dark, 255 = full
led1..led8  output  24 each  scaled GRB words to serializer
busy  output  1  high while the update sweep is running

Behaviour:
- Reset asserted (reset=0), asynchronous: all shadow and active words 0, led1..led8 = 0, busy = 0, all counters 0, blink_phase = 0, level = 0, dir = up.
- Shadow: cfg_we with cfg_addr<8 writes cfg_data[25:0] to shadow[cfg_addr] on the clock edge. cfg_addr 8-15 is a no-op.
- Commit: active[i] <= shadow[i] for all i on the commit edge.
- Write and commit in the same cycle: active takes the pre-write shadow. The write lands in shadow only.
- Prescaler: counts 0..CLK_PER_MS-1 and wraps. ms_tick is a 1-cycle pulse at wrap.
- Blink: an ms counter wraps at BLINK_MS-1 and toggles blink_phase on wrap. First toggle (0->1) occurs at the BLINK_MS-th ms_tick after reset.
- Pulse: a step counter wraps at FADE_STEP_MS-1. On wrap, level steps by ±1 in the current dir.
  - At level 255 while going up: dir flips to down and level becomes 254 on that step. No repeat of 255.
  - Mirror behaviour at 0 while going down.
- Gain per LED, from active mode:
  - off: g = 0
  - solid: g = brightness
  - blink: g = blink_phase ? brightness : 0
  - pulse: g = (brightness*(level+1))>>8
- Channel scaling: out_c = (c*(g+1))>>8, applied to each 8-bit channel G[23:16], R[15:8], B[7:0].
  - g = 255 passes c unchanged.
  - g = 0 yields 0.
- Update sweep (one shared 8x8 multiplier set):
  - Starts on ms_tick or commit.
  - Idx 0..7, one LED per cycle; ledN registers at sweep cycle N-1. busy is high for those 8 cycles.
  - Sweep latency, no gamma: led1 updates 1 cycle after the start edge, led8 8 cycles after.
- Start during an active sweep: not restarted. A pending flag is set and a new sweep begins the cycle after idx 7.
  - At most one pending sweep is held. Further starts while pending merge into it.
- Reset asserted mid-sweep: immediate clear per the reset values above. No partial output survives.
- brightness is sampled per LED when that LED is processed. Changes mid-sweep affect only LEDs not yet processed.

Optional Feature:
- Macro LED_GAMMA_EN.
- Defined: each scaled channel s is further mapped to (s*(s+1))>>8 (gamma 2.0). 0->0, 128->64, 255->255.
  - Adds one pipeline register: every ledN updates 1 cycle later and busy stretches to 9 cycles.
- Undefined: linear output exactly as in Behaviour, 8-cycle sweep.

Test Plan:
- Reset then release, no writes -> led1..led8 = 0x000000, busy = 0; first ms_tick after 100000 cycles yields a sweep with busy high 8 cycles, outputs still 0.
- Write addr0 = 0x01_FF8040 (solid), brightness 255, commit -> led1 = 0xFF8040 within 8 cycles; brightness 127 on next tick -> led1 = 0x7F4020.
- Write addr3 = 0x02_00FF00 (blink), brightness 255, BLINK_MS=2, CLK_PER_MS=10, commit -> led4 = 0x000000, then 0x00FF00 after the sweep triggered by the 2nd ms_tick, back to 0 after the 4th.
- Pulse on addr7 = 0x03_FFFFFF, FADE_STEP_MS=1, CLK_PER_MS=4 -> led8 channels rise monotonically to 0xFF at level 255, then fall; level sequence 254,255,254, never repeats 255.
- cfg_we addr2 = 0x01_112233 in the same cycle as commit -> led3 unchanged (previous active); second commit -> led3 = 0x112233. cfg_addr 9 write -> no output change.
- Commit asserted on sweep cycle 3 -> exactly one follow-up sweep starts the cycle after idx 7; with LED_GAMMA_EN, solid 0x808080 at brightness 255 -> 0x404040, and busy is 9 cycles.

Source files
------------

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Colour/animation source for the 8-LED serial string driver.
//               The host loads per-LED colour+mode words into shadow registers.
//               A commit strobe copies all eight to the active set in one edge.
//               A ms timebase animates blink and triangle-fade pulse. A global
//               brightness gain is applied, and one shared 8x8 multiplier set
//               sweeps the eight LEDs, one per cycle, into the GRB output words.
//
// Ports       : clk         master clock
//               reset       asynchronous, active-low reset
//               cfg_we      shadow write strobe
//               cfg_addr    LED index (0-7 valid, 8-15 ignored)
//               cfg_data    [23:0] GRB colour, [25:24] mode, [31:26] ignored
//                           (mode: 0 off, 1 solid, 2 blink, 3 pulse)
//               commit      single-cycle shadow->active copy strobe
//               brightness  global gain, 0 = dark, 255 = full
//               led1..led8  scaled GRB words to the serializer
//               busy        high while an update sweep is in flight
//
// Build macro : LED_GAMMA_EN - when defined, every scaled channel s is further
//               mapped to (s*(s+1))>>8. This adds one pipeline stage, so each
//               ledN lands one cycle later and busy lasts 9 cycles per sweep.
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int CLK_PER_MS   = 100000,
    parameter int BLINK_MS     = 250,
    parameter int FADE_STEP_MS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        commit,
    input  logic [7:0]  brightness,
    output logic [23:0] led1,
    output logic [23:0] led2,
    output logic [23:0] led3,
    output logic [23:0] led4,
    output logic [23:0] led5,
    output logic [23:0] led6,
    output logic [23:0] led7,
    output logic [23:0] led8,
    output logic        busy
);

    localparam int c_NUM_LED = 8;
    localparam int c_PRE_W   = (CLK_PER_MS   > 1) ? $clog2(CLK_PER_MS)   : 1;
    localparam int c_BLINK_W = (BLINK_MS     > 1) ? $clog2(BLINK_MS)     : 1;
    localparam int c_FADE_W  = (FADE_STEP_MS > 1) ? $clog2(FADE_STEP_MS) : 1;

    localparam logic [c_PRE_W-1:0]   c_PRE_LAST   = c_PRE_W'(CLK_PER_MS - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_MS - 1);
    localparam logic [c_FADE_W-1:0]  c_FADE_LAST  = c_FADE_W'(FADE_STEP_MS - 1);

    localparam logic [1:0] c_MODE_OFF   = 2'd0;
    localparam logic [1:0] c_MODE_SOLID = 2'd1;
    localparam logic [1:0] c_MODE_BLINK = 2'd2;
    localparam logic [1:0] c_MODE_PULSE = 2'd3;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // (c * (g + 1)) >> 8 : maps g = 255 to identity and g = 0 to zero.
    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] g);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, g} + 17'd1);
        return 8'(p >> 8);
    endfunction

    // ------------------------------------------------------------------------
    // Configuration storage
    // ------------------------------------------------------------------------
    logic [25:0] r_shadow [c_NUM_LED];
    logic [25:0] r_active [c_NUM_LED];
    logic        w_unused_cfg;

    assign w_unused_cfg = ^cfg_data[31:26];

    // Commit reads the pre-edge shadow, so a write in the commit cycle only
    // reaches the shadow copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_NUM_LED; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (cfg_we && !cfg_addr[3]) begin
                r_shadow[cfg_addr[2:0]] <= cfg_data[25:0];
            end
            if (commit) begin
                for (int i = 0; i < c_NUM_LED; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Timebase: ms prescaler, blink phase, pulse level
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0]   r_pre_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [c_FADE_W-1:0]  r_fade_cnt;
    logic                 r_blink_phase;
    logic [7:0]           r_level;
    logic                 r_dir_up;
    logic                 w_ms_tick;
    logic                 w_blink_wrap;
    logic                 w_fade_wrap;

    assign w_ms_tick    = (r_pre_cnt == c_PRE_LAST);
    assign w_blink_wrap = w_ms_tick && (r_blink_cnt == c_BLINK_LAST);
    assign w_fade_wrap  = w_ms_tick && (r_fade_cnt == c_FADE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_fade_cnt    <= '0;
            r_blink_phase <= 1'b0;
            r_level       <= 8'd0;
            r_dir_up      <= 1'b1;
        end else begin
            r_pre_cnt <= w_ms_tick ? '0 : r_pre_cnt + 1'b1;

            if (w_ms_tick) begin
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
                r_fade_cnt  <= w_fade_wrap  ? '0 : r_fade_cnt + 1'b1;
            end

            if (w_blink_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end

            // Triangle: the end points 255 and 0 are each visited once per
            // turn; the reversing step moves straight to the neighbour.
            if (w_fade_wrap) begin
                if (r_dir_up) begin
                    if (r_level == 8'd255) begin
                        r_level  <= 8'd254;
                        r_dir_up <= 1'b0;
                    end else begin
                        r_level <= r_level + 8'd1;
                    end
                end else begin
                    if (r_level == 8'd0) begin
                        r_level  <= 8'd1;
                        r_dir_up <= 1'b1;
                    end else begin
                        r_level <= r_level - 8'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sweep controller
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       w_start;
    logic       w_proc;

    assign w_start = w_ms_tick | commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 3'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Starts that arrive mid-sweep collapse into a single pending flag; the
    // follow-up sweep begins immediately after index 7 with no idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pend_nxt  = r_pend;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_RUN;
                    w_idx_nxt   = 3'd0;
                    w_pend_nxt  = 1'b0;
                end
            end
            c_ST_RUN: begin
                if (r_idx == 3'd7) begin
                    w_idx_nxt  = 3'd0;
                    w_pend_nxt = 1'b0;
                    if (!(r_pend || w_start)) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_idx_nxt  = r_idx + 3'd1;
                    w_pend_nxt = r_pend | w_start;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_idx_nxt   = 3'd0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_proc = (r_state == c_ST_RUN);
    end

    // ------------------------------------------------------------------------
    // Shared gain / channel scaling datapath for the LED at r_idx
    // ------------------------------------------------------------------------
    logic [25:0] w_act;
    logic [7:0]  w_gain;
    logic [23:0] w_scaled;

    assign w_act = r_active[r_idx];

    always_comb begin
        w_gain = 8'd0;
        case (w_act[25:24])
            c_MODE_OFF:   w_gain = 8'd0;
            c_MODE_SOLID: w_gain = brightness;
            c_MODE_BLINK: w_gain = r_blink_phase ? brightness : 8'd0;
            // (brightness * (level + 1)) >> 8
            c_MODE_PULSE: w_gain = f_scale(brightness, r_level);
            default:      w_gain = 8'd0;
        endcase
    end

    always_comb begin
        w_scaled = {f_scale(w_act[23:16], w_gain),
                    f_scale(w_act[15:8],  w_gain),
                    f_scale(w_act[7:0],   w_gain)};
    end

    logic [23:0] r_led [c_NUM_LED];

`ifdef LED_GAMMA_EN
    logic        r_pipe_vld;
    logic [2:0]  r_pipe_idx;
    logic [23:0] r_pipe_rgb;

    // Gamma 2.0 is (s*(s+1))>>8, i.e. the same scaling with g = s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= 1'b0;
            r_pipe_idx <= 3'd0;
            r_pipe_rgb <= 24'd0;
            for (int i = 0; i < c_NUM_LED; i++) begin
                r_led[i] <= 24'd0;
            end
        end else begin
            r_pipe_vld <= w_proc;
            r_pipe_idx <= r_idx;
            r_pipe_rgb <= w_scaled;
            if (r_pipe_vld) begin
                r_led[r_pipe_idx] <= {f_scale(r_pipe_rgb[23:16], r_pipe_rgb[23:16]),
                                      f_scale(r_pipe_rgb[15:8],  r_pipe_rgb[15:8]),
                                      f_scale(r_pipe_rgb[7:0],   r_pipe_rgb[7:0])};
            end
        end
    end

    assign busy = w_proc | r_pipe_vld;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_NUM_LED; i++) begin
                r_led[i] <= 24'd0;
            end
        end else if (w_proc) begin
            r_led[r_idx] <= w_scaled;
        end
    end

    assign busy = w_proc;
`endif

    assign led1 = r_led[0];
    assign led2 = r_led[1];
    assign led3 = r_led[2];
    assign led4 = r_led[3];
    assign led5 = r_led[4];
    assign led6 = r_led[5];
    assign led7 = r_led[6];
    assign led8 = r_led[7];

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Directed self-checking bench for led_pattern_gen, run with a
//               shortened timebase (20 clk per ms, 2 ms blink, 1 ms fade step).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int c_CLK_PER_MS   = 20;
    localparam int c_BLINK_MS     = 2;
    localparam int c_FADE_STEP_MS = 1;
    localparam int c_NSAMP        = 536;
`ifdef LED_GAMMA_EN
    localparam int c_SWEEP = 9;
    localparam int c_L1    = 2;
    localparam int c_PK2TR = 270;
`else
    localparam int c_SWEEP = 8;
    localparam int c_L1    = 1;
    localparam int c_PK2TR = 255;
`endif

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        commit;
    logic [7:0]  brightness;
    logic [23:0] led1, led2, led3, led4, led5, led6, led7, led8;
    logic        busy;

    int n_checks;
    int n_fail;
    int s [c_NSAMP];

    led_pattern_gen #(
        .CLK_PER_MS  (c_CLK_PER_MS),
        .BLINK_MS    (c_BLINK_MS),
        .FADE_STEP_MS(c_FADE_STEP_MS)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .commit    (commit),
        .brightness(brightness),
        .led1      (led1),
        .led2      (led2),
        .led3      (led3),
        .led4      (led4),
        .led5      (led5),
        .led6      (led6),
        .led7      (led7),
        .led8      (led8),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-channel transfer after linear scaling.
    function automatic logic [7:0] f_ch(input logic [7:0] v);
`ifdef LED_GAMMA_EN
        logic [16:0] p;
        p = {9'd0, v} * ({9'd0, v} + 17'd1);
        return 8'(p >> 8);
`else
        return v;
`endif
    endfunction

    function automatic logic [23:0] f_exp(input logic [23:0] c);
        return {f_ch(c[23:16]), f_ch(c[15:8]), f_ch(c[7:0])};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy_high(input string tag);
        logic to;
        to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy) begin
                to = 1'b0;
                break;
            end
        end
        check(tag, {31'd0, to}, 32'd0);
    endtask

    // Wait for the next (or current) sweep to finish.
    task automatic wait_sweep(input string tag);
        logic seen;
        logic done;
        seen = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check(tag, {31'd0, ~done}, 32'd0);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int cyc;
        int cnt;
        int pk;
        int tr;
        int bad;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = 4'd0;
        cfg_data   = 32'd0;
        commit     = 1'b0;
        brightness = 8'd255;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_led1", {8'd0, led1}, 32'd0);
        check("rst_led4", {8'd0, led4}, 32'd0);
        check("rst_led8", {8'd0, led8}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // ---------------- first ms tick sweep ----------------
        reset = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!busy && cyc < 100);
        check("first_tick_cycle", cyc, 20);
        len = 0;
        while (busy && len < 50) begin
            len++;
            @(negedge clk);
        end
        check("first_sweep_len", len, c_SWEEP);
        check("idle_led1", {8'd0, led1}, 32'd0);
        check("idle_led8", {8'd0, led8}, 32'd0);

        // ---------------- blink on LED4 ----------------
        cfg_write(4'd3, 32'h0200_FF00);
        do_commit();
        wait_sweep("blink_commit_to");
        check("blink_phase0", {8'd0, led4}, 32'h0000_0000);
        wait_sweep("blink_t2_to");
        check("blink_tick2_on", {8'd0, led4}, 32'h0000_FF00);
        wait_sweep("blink_t3_to");
        check("blink_tick3_on", {8'd0, led4}, 32'h0000_FF00);
        wait_sweep("blink_t4_to");
        check("blink_tick4_off", {8'd0, led4}, 32'h0000_0000);

        // ---------------- pulse on LED8 ----------------
        cfg_write(4'd7, 32'h03FF_FFFF);
        do_commit();
        wait_sweep("pulse_commit_to");
        for (int i = 0; i < c_NSAMP; i++) begin
            wait_sweep("pulse_step_to");
            s[i] = int'(led8[7:0]);
        end
        cnt = 0;
        pk  = 0;
        for (int i = 0; i < c_NSAMP; i++) begin
            if (s[i] == 255) begin
                cnt++;
                pk = i;
            end
        end
        check("pulse_peak_once", cnt, 1);
        if (pk > 0 && pk < c_NSAMP - 1) begin
            check("pulse_pre_peak", s[pk-1], {24'd0, f_ch(8'd254)});
            check("pulse_post_peak", s[pk+1], {24'd0, f_ch(8'd254)});
        end
        bad = 0;
        for (int i = 0; i < pk; i++) begin
            if (s[i+1] < s[i]) bad++;
        end
        check("pulse_rise_monotonic", bad, 0);
        tr = pk;
        while (tr < c_NSAMP - 1 && s[tr+1] <= s[tr]) tr++;
        check("pulse_trough_val", s[tr], 0);
        check("pulse_peak_to_trough", tr - pk, c_PK2TR);
        if (tr < c_NSAMP - 1) begin
            check("pulse_after_trough", s[tr+1], 1);
        end
`ifndef LED_GAMMA_EN
        cnt = 0;
        for (int i = pk; i < c_NSAMP; i++) begin
            if (s[i] == 0) cnt++;
        end
        check("pulse_zero_once", cnt, 1);
`endif

        // ---------------- solid on LED1 with brightness ----------------
        cfg_write(4'd0, 32'h01FF_8040);
        do_commit();
        wait_sweep("solid_commit_to");
        check("solid_full", {8'd0, led1}, {8'd0, f_exp(24'hFF8040)});
        brightness = 8'd127;
        wait_sweep("solid_dim_to");
        check("solid_b127", {8'd0, led1}, {8'd0, f_exp(24'h7F4020)});
        brightness = 8'd255;
        wait_sweep("solid_restore_to");

        // ---------------- write + commit in one cycle ----------------
        cfg_we   = 1'b1;
        cfg_addr = 4'd2;
        cfg_data = 32'h0111_2233;
        commit   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        commit   = 1'b0;
        wait_sweep("samecyc_to");
        check("samecyc_led3_old", {8'd0, led3}, 32'd0);
        do_commit();
        wait_sweep("commit2_to");
        check("commit2_led3", {8'd0, led3}, {8'd0, f_exp(24'h112233)});

        // ---------------- out-of-range address ----------------
        cfg_write(4'd9, 32'h01AA_BBCC);
        do_commit();
        wait_sweep("addr9_to");
        check("addr9_led2", {8'd0, led2}, 32'd0);
        check("addr9_led3", {8'd0, led3}, {8'd0, f_exp(24'h112233)});
        check("addr9_led1", {8'd0, led1}, {8'd0, f_exp(24'hFF8040)});

        // ---------------- commit mid-sweep -> one follow-up ----------------
        cfg_write(4'd0, 32'h0180_8080);
        wait_busy_high("c3_rise_to");
        @(negedge clk);
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit   = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 32'h0120_4060;
        @(negedge clk);
        cfg_we   = 1'b0;
        len = 5;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            len++;
        end
        check("c3_busy_run", len, c_SWEEP + 8);
        check("c3_led1", {8'd0, led1}, {8'd0, f_exp(24'h808080)});

        // ---------------- commit-to-output latency ----------------
        wait_sweep("lat_sync_to");
        do_commit();
        repeat (c_L1 - 1) @(negedge clk);
        check("lat_led1_old", {8'd0, led1}, {8'd0, f_exp(24'h808080)});
        @(negedge clk);
        check("lat_led1_new", {8'd0, led1}, {8'd0, f_exp(24'h204060)});
        len = c_L1 + 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            len++;
        end
        check("lat_busy_len", len, c_SWEEP);

        // ---------------- asynchronous reset mid-sweep ----------------
        wait_busy_high("rst_rise_to");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_led1", {8'd0, led1}, 32'd0);
        check("midrst_led4", {8'd0, led4}, 32'd0);
        check("midrst_led8", {8'd0, led8}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
